// File: rtl/pace_output_arbiter.sv
// Round-robin arbiter sharing one ventricular pacing output stage among N_CH VVI channels.
// Each grant drives a fixed-width pulse, then a recharge holdoff; starved requests are dropped.
module pace_output_arbiter #(
    parameter int N_CH            = 4,
    parameter int PULSE_CYCLES    = 8,
    parameter int RECHARGE_CYCLES = 32,
    parameter int MAX_WAIT        = 64,
    parameter int CW              = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         VPace_eI,
    output logic                    Pulse_eO,
    output logic [$clog2(N_CH)-1:0] PulseChan,
    output logic                    Recharge_eO,
    output logic [N_CH-1:0]         PaceDone_eO,
    output logic [N_CH-1:0]         Dropped_eO,
    output logic [N_CH-1:0]         Pending
);
    localparam int CHW = $clog2(N_CH);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] RECH_LAST  = CW'(RECHARGE_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_RECH  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CHW-1:0]  r_rr;
    logic [CHW-1:0]  r_chan;
    logic [CHW-1:0]  w_grant_idx;
    logic            w_found;
    logic            w_grant;
    logic [N_CH-1:0] w_grant_oh;
    logic [N_CH-1:0] r_pend;
    logic [N_CH-1:0] w_pend_nxt;
    logic [N_CH-1:0] r_drop;
    logic [N_CH-1:0] w_drop_nxt;
    logic [N_CH-1:0] r_done;
    logic [N_CH-1:0] w_done_nxt;
    logic            r_pulse;
    logic            r_rech;
    logic [CW-1:0]   r_wait     [N_CH];
    logic [CW-1:0]   w_wait_nxt [N_CH];

    // First pending channel at or above the rr pointer, wrapping.
    always_comb begin
        logic [CHW-1:0] v_idx;
        w_found     = 1'b0;
        w_grant_idx = '0;
        v_idx       = '0;
        for (int k = 0; k < N_CH; k++) begin
            v_idx = CHW'((int'(r_rr) + k) % N_CH);
            if (!w_found && r_pend[v_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = v_idx;
            end
        end
    end

    assign w_grant = w_found && (r_state == S_IDLE);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_grant_oh[i] = w_grant && (w_grant_idx == CHW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = '0;
                end
            end
            S_PULSE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = S_RECH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_RECH: begin
                if (r_cnt == RECH_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_done_nxt = '0;
        if (r_state == S_PULSE && w_state_nxt == S_RECH) begin
            w_done_nxt[r_chan] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse <= 1'b0;
            r_rech  <= 1'b0;
            r_done  <= '0;
            r_chan  <= '0;
            r_rr    <= '0;
        end else begin
            r_pulse <= (w_state_nxt == S_PULSE);
            r_rech  <= (w_state_nxt == S_RECH);
            r_done  <= w_done_nxt;
            if (w_grant) begin
                r_chan <= w_grant_idx;
                r_rr   <= CHW'((int'(w_grant_idx) + 1) % N_CH);
            end
        end
    end

    // Grant beats drop; a fresh request arriving on the drop edge keeps the channel pending.
    always_comb begin
        w_pend_nxt = r_pend;
        w_drop_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_wait_nxt[i] = r_wait[i];
            if (w_grant_oh[i]) begin
                w_pend_nxt[i] = VPace_eI[i];
                w_wait_nxt[i] = '0;
            end else if (r_pend[i]) begin
                if (r_wait[i] >= WAIT_LAST) begin
                    w_wait_nxt[i] = '0;
                    w_pend_nxt[i] = VPace_eI[i];
                    w_drop_nxt[i] = ~VPace_eI[i];
                end else begin
                    w_wait_nxt[i] = r_wait[i] + CW'(1);
                end
            end else if (VPace_eI[i]) begin
                w_pend_nxt[i] = 1'b1;
                w_wait_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            r_drop <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            r_pend <= w_pend_nxt;
            r_drop <= w_drop_nxt;
            for (int i = 0; i < N_CH; i++) begin
                r_wait[i] <= w_wait_nxt[i];
            end
        end
    end

    assign Pulse_eO    = r_pulse;
    assign PulseChan   = r_chan;
    assign Recharge_eO = r_rech;
    assign PaceDone_eO = r_done;
    assign Dropped_eO  = r_drop;
    assign Pending     = r_pend;

endmodule
